// File: rtl/clk_mon_pkg.sv
// Shared types, default constants and helpers for the clock period monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } mon_state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_EXP_PERIOD = 10;
    localparam int DEF_TOL        = 1;
    localparam int DEF_TIMEOUT    = 64;

    // Increment that sticks at max_value instead of wrapping; callers
    // zero-extend their counters to 32 bits, so counters up to 32 bits wide fit.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, with one-cycle rise and
// fall pulses derived from the synchronized value and its previous sample.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of an asynchronous clock in clk cycles,
// flagging out-of-tolerance periods and a stuck/missing clock.
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic             mon_clk,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             err_period,
    output logic             err_stuck,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] CNT_ONES  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    logic rise;
    logic fall;

    mon_state_t       state, state_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_nxt;
    logic [CNT_W-1:0] since_edge, since_nxt;
    logic [CNT_W-1:0] high_tmp, high_tmp_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt, edge_nxt;
    logic             meas_nxt, err_period_nxt, err_stuck_nxt;
    logic             period_bad, set_period, set_stuck;
    logic signed [CNT_W:0] diff, mag;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mon_clk),
        .rise (rise),
        .fall (fall)
    );

    // Distance of the running count from the expected period, done one bit
    // wider and signed so short periods give a negative difference.
    always_comb begin
        diff       = $signed({1'b0, cyc_cnt}) - EXP_S;
        mag        = diff[CNT_W] ? -diff : diff;
        period_bad = (mag > TOL_S);
    end

    // Next-state and next-output logic; en low overrides everything and
    // throws away any half-finished measurement.
    always_comb begin
        state_nxt    = state;
        cyc_nxt      = CNT_W'(sat_inc(32'(cyc_cnt), 32'(CNT_ONES)));
        since_nxt    = CNT_W'(sat_inc(32'(since_edge), 32'(CNT_ONES)));
        high_tmp_nxt = high_tmp;
        period_nxt   = period_o;
        high_nxt     = high_o;
        edge_nxt     = edge_cnt;
        meas_nxt     = 1'b0;
        set_period   = 1'b0;
        set_stuck    = 1'b0;

        if (rise || fall) begin
            since_nxt = CNT_ONE;
        end

        case (state)
            IDLE: begin
                cyc_nxt   = '0;
                since_nxt = '0;
                state_nxt = SYNC;
            end
            SYNC: begin
                if (rise) begin
                    state_nxt = HIGH;
                    cyc_nxt   = CNT_ONE;
                    edge_nxt  = edge_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt    = LOW;
                    high_tmp_nxt = cyc_cnt;
                end else if (since_edge >= TIMEOUT_C) begin
                    state_nxt = SYNC;
                    set_stuck = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt  = HIGH;
                    period_nxt = cyc_cnt;
                    high_nxt   = high_tmp;
                    meas_nxt   = 1'b1;
                    cyc_nxt    = CNT_ONE;
                    edge_nxt   = edge_cnt + CNT_ONE;
                    set_period = period_bad;
                end else if (since_edge >= TIMEOUT_C) begin
                    state_nxt = SYNC;
                    set_stuck = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!en) begin
            state_nxt    = IDLE;
            cyc_nxt      = '0;
            since_nxt    = '0;
            high_tmp_nxt = high_tmp;
            period_nxt   = period_o;
            high_nxt     = high_o;
            edge_nxt     = edge_cnt;
            meas_nxt     = 1'b0;
            set_period   = 1'b0;
            set_stuck    = 1'b0;
        end

        err_period_nxt = set_period | (err_period & ~clr_err);
        err_stuck_nxt  = set_stuck  | (err_stuck  & ~clr_err);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            since_edge <= '0;
            high_tmp   <= '0;
            period_o   <= '0;
            high_o     <= '0;
            edge_cnt   <= '0;
            meas_valid <= 1'b0;
            err_period <= 1'b0;
            err_stuck  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cyc_cnt    <= cyc_nxt;
            since_edge <= since_nxt;
            high_tmp   <= high_tmp_nxt;
            period_o   <= period_nxt;
            high_o     <= high_nxt;
            edge_cnt   <= edge_nxt;
            meas_valid <= meas_nxt;
            err_period <= err_period_nxt;
            err_stuck  <= err_stuck_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Self-checking bench for clk_period_monitor: a generated mon_clk, a
// scoreboard of expected period/high results, and one task per scenario.
module tb_clk_period_monitor;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_err;
    logic        mon_clk;
    logic        meas_valid;
    logic [15:0] period_o;
    logic [15:0] high_o;
    logic [15:0] edge_cnt;
    logic        err_period;
    logic        err_stuck;
    logic [1:0]  state_o;

    typedef struct {
        int period;
        int high;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   mon_per  = 10;
    int   mon_hi   = 5;
    bit   mon_run  = 1'b0;
    logic mon_hold = 1'b0;

    clk_period_monitor #(
        .CNT_W      (16),
        .EXP_PERIOD (10),
        .TOL        (1),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr_err    (clr_err),
        .mon_clk    (mon_clk),
        .meas_valid (meas_valid),
        .period_o   (period_o),
        .high_o     (high_o),
        .edge_cnt   (edge_cnt),
        .err_period (err_period),
        .err_stuck  (err_stuck),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // mon_clk generator: integer number of clk cycles per period, changing
    // 3 ns after a clk rise so it never coincides with a sampling edge.
    initial begin : mon_gen
        int phase;
        phase   = 0;
        mon_clk = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (mon_run) begin
                mon_clk = (phase < mon_hi);
                phase   = (phase + 1 >= mon_per) ? 0 : phase + 1;
            end else begin
                mon_clk = mon_hold;
                phase   = 0;
            end
        end
    end

    // Scoreboard: every meas_valid pulse must match the oldest expected result.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (meas_valid === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_result: got period_o=%0d high_o=%0d, required no meas_valid",
                         period_o, high_o);
            end else begin
                e = sb_q.pop_front();
                if (period_o !== 16'(e.period) || high_o !== 16'(e.high)) begin
                    n_bad++;
                    $display("[TB] FAIL result: got period_o=%0d high_o=%0d, required period_o=%0d high_o=%0d",
                             period_o, high_o, e.period, e.high);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_exp(input int period, input int high);
        exp_t e;
        e.period = period;
        e.high   = high;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int waited = 0;
        while (sb_q.size() != 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL %s_drain: got %0d results pending after %0d cycles, required 0",
                     tag, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        en       = 1'b0;
        clr_err  = 1'b0;
        mon_run  = 1'b0;
        mon_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        en      = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (meas_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_meas_valid: got %b, required 0", meas_valid); end
        n_cmp++; if (period_o !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_period: got %0d, required 0", period_o); end
        n_cmp++; if (high_o !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_high: got %0d, required 0", high_o); end
        n_cmp++; if (edge_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_edge_cnt: got %0d, required 0", edge_cnt); end
        n_cmp++; if (err_period !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err_period: got %b, required 0", err_period); end
        n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err_stuck: got %b, required 0", err_stuck); end
        n_cmp++; if (state_o !== ST_IDLE) begin n_bad++; $display("[TB] FAIL reset_state: got %0d, required %0d", state_o, ST_IDLE); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (state_o !== ST_IDLE) begin n_bad++; $display("[TB] FAIL idle_without_en: got %0d, required %0d", state_o, ST_IDLE); end
    endtask

    task automatic test_nominal();
        do_reset();
        mon_per = 10;
        mon_hi  = 5;
        for (int i = 0; i < 4; i++) push_exp(10, 5);
        mon_run = 1'b1;
        en      = 1'b1;
        wait_drain(200, "nominal");
        n_cmp++; if (edge_cnt !== 16'd5) begin n_bad++; $display("[TB] FAIL nominal_edge_cnt: got %0d, required 5", edge_cnt); end
        n_cmp++; if (err_period !== 1'b0) begin n_bad++; $display("[TB] FAIL nominal_err_period: got %b, required 0", err_period); end
        n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("[TB] FAIL nominal_err_stuck: got %b, required 0", err_stuck); end
        en      = 1'b0;
        mon_run = 1'b0;
    endtask

    task automatic test_period_err();
        do_reset();
        mon_per = 13;
        mon_hi  = 6;
        push_exp(13, 6);
        mon_run = 1'b1;
        en      = 1'b1;
        wait_drain(200, "period_err_first");
        n_cmp++; if (err_period !== 1'b1) begin n_bad++; $display("[TB] FAIL period_err_set: got %b, required 1", err_period); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (err_period !== 1'b0) begin n_bad++; $display("[TB] FAIL period_err_clear: got %b, required 0", err_period); end
        push_exp(13, 6);
        wait_drain(100, "period_err_second");
        n_cmp++; if (err_period !== 1'b1) begin n_bad++; $display("[TB] FAIL period_err_reset: got %b, required 1", err_period); end
        n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("[TB] FAIL period_err_stuck: got %b, required 0", err_stuck); end
        en      = 1'b0;
        mon_run = 1'b0;
    endtask

    task automatic test_stuck();
        do_reset();
        mon_per = 10;
        mon_hi  = 5;
        push_exp(10, 5);
        mon_run = 1'b1;
        en      = 1'b1;
        wait_drain(200, "stuck_pre");
        mon_hold = 1'b1;
        mon_run  = 1'b0;
        repeat (63) @(negedge clk);
        n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("[TB] FAIL stuck_early: got %b after 63 cycles, required 0", err_stuck); end
        @(negedge clk);
        n_cmp++; if (err_stuck !== 1'b1) begin n_bad++; $display("[TB] FAIL stuck_at_timeout: got %b after 64 cycles, required 1", err_stuck); end
        n_cmp++; if (state_o !== ST_SYNC) begin n_bad++; $display("[TB] FAIL stuck_state: got %0d, required %0d", state_o, ST_SYNC); end
        push_exp(10, 5);
        mon_run = 1'b1;
        wait_drain(200, "stuck_recover");
        n_cmp++; if (err_stuck !== 1'b1) begin n_bad++; $display("[TB] FAIL stuck_sticky: got %b, required 1", err_stuck); end
        n_cmp++; if (edge_cnt !== 16'd4) begin n_bad++; $display("[TB] FAIL stuck_edge_cnt: got %0d, required 4", edge_cnt); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("[TB] FAIL stuck_clear: got %b, required 0", err_stuck); end
        en      = 1'b0;
        mon_run = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        mon_per = 10;
        mon_hi  = 5;
        push_exp(10, 5);
        mon_run = 1'b1;
        en      = 1'b1;
        wait_drain(200, "rst_mid");
        repeat (2) @(negedge clk);
        n_cmp++; if (state_o !== ST_HIGH) begin n_bad++; $display("[TB] FAIL rst_mid_pre_state: got %0d, required %0d", state_o, ST_HIGH); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (state_o !== ST_IDLE) begin n_bad++; $display("[TB] FAIL rst_mid_state: got %0d, required %0d", state_o, ST_IDLE); end
        n_cmp++; if (period_o !== 16'd0 || high_o !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_mid_results: got period_o=%0d high_o=%0d, required 0 and 0", period_o, high_o); end
        n_cmp++; if (edge_cnt !== 16'd0 || meas_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_edge_valid: got edge_cnt=%0d meas_valid=%b, required 0 and 0", edge_cnt, meas_valid); end
        rst     = 1'b0;
        en      = 1'b0;
        mon_run = 1'b0;
    endtask

    task automatic test_en_drop();
        do_reset();
        mon_per = 12;
        mon_hi  = 6;
        push_exp(12, 6);
        mon_run = 1'b1;
        en      = 1'b1;
        wait_drain(200, "en_drop_first");
        n_cmp++; if (err_period !== 1'b1) begin n_bad++; $display("[TB] FAIL en_drop_err_set: got %b, required 1", err_period); end
        repeat (8) @(negedge clk);
        n_cmp++; if (state_o !== ST_LOW) begin n_bad++; $display("[TB] FAIL en_drop_pre_state: got %0d, required %0d", state_o, ST_LOW); end
        en = 1'b0;
        @(negedge clk);
        n_cmp++; if (state_o !== ST_IDLE) begin n_bad++; $display("[TB] FAIL en_drop_idle: got %0d, required %0d", state_o, ST_IDLE); end
        n_cmp++; if (err_period !== 1'b1) begin n_bad++; $display("[TB] FAIL en_drop_err_kept: got %b, required 1", err_period); end
        repeat (5) @(negedge clk);
        push_exp(12, 6);
        en = 1'b1;
        wait_drain(200, "en_drop_resume");
        n_cmp++; if (edge_cnt !== 16'd4) begin n_bad++; $display("[TB] FAIL en_drop_edge_cnt: got %0d, required 4", edge_cnt); end
        en      = 1'b0;
        mon_run = 1'b0;
    endtask

    task automatic test_clr_same_cycle();
        int waited = 0;
        do_reset();
        mon_per = 12;
        mon_hi  = 6;
        push_exp(12, 6);
        mon_run = 1'b1;
        en      = 1'b1;
        while (state_o !== ST_LOW && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (state_o !== ST_LOW) begin
            n_bad++;
            $display("[TB] FAIL clr_same_reach_low: got state %0d after %0d cycles, required %0d", state_o, waited, ST_LOW);
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (err_period !== 1'b0) begin n_bad++; $display("[TB] FAIL clr_same_pre_err: got %b, required 0", err_period); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (meas_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL clr_same_valid: got %b, required 1", meas_valid); end
        n_cmp++; if (err_period !== 1'b1) begin n_bad++; $display("[TB] FAIL clr_same_set_wins: got %b, required 1", err_period); end
        wait_drain(20, "clr_same");
        en      = 1'b0;
        mon_run = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        clr_err = 1'b0;
        test_reset();
        test_nominal();
        test_period_err();
        test_stuck();
        test_rst_mid();
        test_en_drop();
        test_clr_same_cycle();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL final_queue: got %0d pending results, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
